seq_bit_serializer: RTL and testbench
=====================================

Name: seq_bit_serializer

Overview:
- Parallel-to-serial front end for the bit-serial sequence detectors; converts handshaked WIDTH-bit words into a continuous one-bit-per-enabled-cycle stream that drives a detector's serial x input.
- One shift register plus a one-word holding register, so back-to-back words stream with no idle bit between them.
- Sits directly upstream of the sequence detector stage.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts a word this cycle. Transfer occurs when in_valid && in_ready at a rising edge.
- ser_en  input  1  bit-advance enable; tie to 1 for one bit per clock.
- ser_out  output  1  current serial bit (registered).
- ser_valid  output  1  ser_out carries a data bit (or parity bit).
- word_start  output  1  high while ser_out presents the first bit of a word.
- busy  output  1  shift register or holding register occupied.

Behaviour:
- Reset: already decided — one clock; reset is asynchronous and active-high. While rst=1, ser_out=0, ser_valid=0, word_start=0, busy=0, holding register empty, bit counter=0, FSM=IDLE, in_ready=0. After rst falls, in_ready=1 immediately. Reset mid-word discards the shift and holding contents; there is no partial-word recovery.
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - ser_valid=0, ser_out=0.
  - On transfer, load the word into the shift register, set bit counter=0, go to SHIFT.
  - At the same edge, ser_out shows the first bit and ser_valid=word_start=1. Latency is therefore 1 cycle from the accept edge to the first bit.
- SHIFT: each edge with ser_en=1 advances to the next bit and increments the counter. ser_en=0 holds ser_out, ser_valid and the counter unchanged.
- Frame length F = WIDTH (WIDTH+1 with parity feature).
- Last-bit edge (counter=F-1 and ser_en=1). Choose the next word as follows:
  - If the holding register is full, move it into the shift register, present its first bit at that same edge with word_start=1, and stay in SHIFT (zero-gap).
  - Else if a transfer occurs on that edge, bypass the word straight into the shift register (zero-gap).
  - Else go to IDLE and ser_valid=0.
- in_ready = !hold_full && !rst.
  - A transfer while in SHIFT that is not a last-bit edge fills the holding register.
  - A full holding register blocks input until it drains.
- busy = (state==SHIFT) || hold_full.
- in_data is sampled only at the transfer edge; later changes are ignored.

Optional Feature:
- Macro SER_PARITY_EN.
- Defined: each frame carries one extra bit after the WIDTH data bits, equal to the XOR of all WIDTH data bits (even parity). F=WIDTH+1; ser_valid=1 during the parity bit; word_start=0 on it.
- Undefined: F=WIDTH and no parity logic exists.

Test Plan:
- WIDTH=8, MSB_FIRST=1, ser_en=1, single word 0x36 -> ser_out 0,0,1,1,0,1,1,0 on 8 consecutive cycles starting 1 cycle after accept; word_start only on the first bit; then ser_valid=0 and busy=0.
- Back-to-back words 0xDB then 0x6D with in_valid held -> 16 contiguous bits 1101101101101101 with no gap; word_start at bits 0 and 8; in_ready drops while the holding register is full.
- MSB_FIRST=0, word 0x0D -> ser_out 1,0,1,1,0,0,0,0.
- ser_en low for 3 cycles after the 2nd bit of 0xF0 -> ser_out holds 1 for those cycles; total frame length = 8 enabled cycles; sequence unchanged.
- rst asserted mid-word (after 4 bits of 0xAA, with 0x55 held) -> outputs 0 asynchronously; in_ready=1 after release; the next word 0x81 emits 1,0,0,0,0,0,0,1 with no residue from 0xAA/0x55.
- SER_PARITY_EN defined, word 0x07 -> 9 bits 0,0,0,0,0,1,1,1,1; word 0x03 -> parity bit 0.

Source files
------------

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: parallel-to-serial front end for the bit-serial sequence detectors.
// Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per enabled
// cycle. A one-word holding register lets back-to-back words stream with no idle bit.
// Optional build macro: SER_PARITY_EN appends an even-parity bit to every frame.
module seq_bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             ser_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_start,
    output logic             busy
);

`ifdef SER_PARITY_EN
    localparam int unsigned FRAME = WIDTH + 1;
`else
    localparam int unsigned FRAME = WIDTH;
`endif
    localparam int unsigned      CNT_W    = $clog2(FRAME);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME - 1);
`ifdef SER_PARITY_EN
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WIDTH - 1);
`endif

    // Elaboration-time guard on the supported word width
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("seq_bit_serializer: WIDTH must be in 2..32");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;      // bits still to be presented after the current one
    logic [WIDTH-1:0] hold_reg;
    logic             hold_full;
    logic [CNT_W-1:0] cnt;
`ifdef SER_PARITY_EN
    logic             parity;
`endif

    logic             xfer_c;
    logic             last_c;
    logic             load_c;
    logic             hold_fill_c;
    logic [WIDTH-1:0] load_word_c;
    logic             next_bit_c;

    // First bit of a word in the configured shift order
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Word with its leading bit removed, leaving the next bit at the output end
    function automatic logic [WIDTH-1:0] drop_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    // Ready goes low with reset so nothing is accepted while the block is cleared
    assign in_ready = !hold_full && !rst;

    // Handshake, last-bit and word-selection decode
    always_comb begin
        xfer_c      = in_valid && in_ready;
        last_c      = (cnt == LAST_IDX);
        load_word_c = hold_full ? hold_reg : in_data;
        next_bit_c  = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
        load_c      = 1'b0;
        hold_fill_c = 1'b0;
        if (state == IDLE) begin
            load_c = xfer_c;
        end else begin
            load_c      = ser_en && last_c && (hold_full || xfer_c);
            hold_fill_c = xfer_c && !(ser_en && last_c);
        end
    end

    // Holding register: captures a word that arrives while a frame is mid-flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_reg  <= '0;
            hold_full <= 1'b0;
        end else if (hold_fill_c) begin
            hold_reg  <= in_data;
            hold_full <= 1'b1;
        end else if (load_c) begin
            hold_full <= 1'b0;
        end
    end

    // Serializer FSM with registered stream outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            ser_out    <= 1'b0;
            ser_valid  <= 1'b0;
            word_start <= 1'b0;
            busy       <= 1'b0;
`ifdef SER_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (load_c) begin
                        state      <= SHIFT;
                        shreg      <= drop_bit(load_word_c);
                        cnt        <= '0;
                        ser_out    <= first_bit(load_word_c);
                        ser_valid  <= 1'b1;
                        word_start <= 1'b1;
                        busy       <= 1'b1;
`ifdef SER_PARITY_EN
                        parity     <= ^load_word_c;
`endif
                    end else begin
                        ser_out    <= 1'b0;
                        ser_valid  <= 1'b0;
                        word_start <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (load_c) begin
                        // Zero-gap hand-over to the held or bypassed word
                        shreg      <= drop_bit(load_word_c);
                        cnt        <= '0;
                        ser_out    <= first_bit(load_word_c);
                        ser_valid  <= 1'b1;
                        word_start <= 1'b1;
                        busy       <= 1'b1;
`ifdef SER_PARITY_EN
                        parity     <= ^load_word_c;
`endif
                    end else if (ser_en && last_c) begin
                        state      <= IDLE;
                        ser_out    <= 1'b0;
                        ser_valid  <= 1'b0;
                        word_start <= 1'b0;
                        busy       <= 1'b0;
                    end else if (ser_en) begin
                        shreg      <= drop_bit(shreg);
                        cnt        <= cnt + CNT_W'(1);
                        word_start <= 1'b0;
`ifdef SER_PARITY_EN
                        ser_out    <= (cnt == DATA_LAST) ? parity : next_bit_c;
`else
                        ser_out    <= next_bit_c;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Testbench for seq_bit_serializer: an MSB-first and an LSB-first instance share one
// stimulus stream and are compared against a bit-queue model of the output stream.
module tb_seq_bit_serializer;

    localparam int unsigned W = 8;
`ifdef SER_PARITY_EN
    localparam int unsigned F = W + 1;
`else
    localparam int unsigned F = W;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         ser_en;
    logic         rdy_m, out_m, val_m, ws_m, busy_m;
    logic         rdy_l, out_l, val_l, ws_l, busy_l;

    always #5 clk = ~clk;

    seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_m),
        .ser_en(ser_en), .ser_out(out_m), .ser_valid(val_m), .word_start(ws_m), .busy(busy_m)
    );

    seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_l),
        .ser_en(ser_en), .ser_out(out_l), .ser_valid(val_l), .word_start(ws_l), .busy(busy_l)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stream model: every accepted word becomes F queue entries; the head is "on the wire"
    typedef struct {
        logic [W-1:0] w;
        int           k;
    } ent_t;

    ent_t         q[$];
    ent_t         cur;
    logic         cur_valid;
    logic [31:0]  cap_m, cap_l;

    function automatic logic bit_of(input ent_t e, input logic msb);
        if (e.k >= int'(W)) return ^e.w;
        return msb ? e.w[int'(W) - 1 - e.k] : e.w[e.k];
    endfunction

    // Words accepted but not yet started sit in the queue with their k==0 entry
    function automatic int waiting();
        int n = 0;
        foreach (q[i]) if (q[i].k == 0) n++;
        return n;
    endfunction

    function automatic void push_word(input logic [W-1:0] w);
        for (int k = 0; k < int'(F); k++) q.push_back('{w: w, k: k});
    endfunction

    task automatic check_outputs();
        logic er;
        logic ews;
        er  = !rst && (waiting() == 0);
        ews = cur_valid && (cur.k == 0);
        chk("in_ready_msb", 32'(rdy_m), 32'(er));
        chk("in_ready_lsb", 32'(rdy_l), 32'(er));
        chk("ser_valid_msb", 32'(val_m), 32'(cur_valid));
        chk("ser_valid_lsb", 32'(val_l), 32'(cur_valid));
        chk("word_start_msb", 32'(ws_m), 32'(ews));
        chk("word_start_lsb", 32'(ws_l), 32'(ews));
        chk("ser_out_msb", 32'(out_m), 32'(cur_valid ? bit_of(cur, 1'b1) : 1'b0));
        chk("ser_out_lsb", 32'(out_l), 32'(cur_valid ? bit_of(cur, 1'b0) : 1'b0));
        chk("busy_msb", 32'(busy_m), 32'(cur_valid));
        chk("busy_lsb", 32'(busy_l), 32'(cur_valid));
    endtask

    // One clock: check at the falling edge, drive, then advance the model at the rising edge
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic en);
        logic xfer;
        @(negedge clk);
        check_outputs();
        in_valid = v;
        in_data  = d;
        ser_en   = en;
        xfer     = v && !rst && (waiting() == 0);
        if (val_m && en) cap_m = {cap_m[30:0], out_m};
        if (val_l && en) cap_l = {cap_l[30:0], out_l};
        @(posedge clk);
        if (!cur_valid) begin
            if (xfer) begin
                push_word(d);
                cur       = q.pop_front();
                cur_valid = 1'b1;
            end
        end else if (en) begin
            if (xfer) push_word(d);
            if (q.size() > 0) cur = q.pop_front();
            else cur_valid = 1'b0;
        end else if (xfer) begin
            push_word(d);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, W'($urandom), 1'b1);
    endtask

    task automatic clear_cap();
        cap_m = '0;
        cap_l = '0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        ser_en    = 1'b1;
        cur_valid = 1'b0;
        cur       = '{w: '0, k: 0};
        clear_cap();

        // Reset state
        #3;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 32'(rdy_m), 32'd1);

`ifndef SER_PARITY_EN
        // Single word, MSB first -> 0,0,1,1,0,1,1,0
        clear_cap();
        cycle(1'b1, 8'h36, 1'b1);
        idle(12);
        chk("word36_msb", cap_m[7:0], 32'h36);
        chk("word36_lsb", cap_l[7:0], 32'h6C);

        // LSB-first order of 0x0D -> 1,0,1,1,0,0,0,0
        clear_cap();
        cycle(1'b1, 8'h0D, 1'b1);
        idle(12);
        chk("word0d_lsb", cap_l[7:0], 32'hB0);

        // Back-to-back words stream with no gap; second one waits in the holding register
        clear_cap();
        cycle(1'b1, 8'hDB, 1'b1);
        cycle(1'b1, 8'h6D, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        chk("ready_low_hold_full", 32'(rdy_m), 32'd0);
        idle(20);
        chk("b2b_stream", cap_m[15:0], 32'hDB6D);

        // Stall after the second bit of 0xF0 holds the current bit
        clear_cap();
        cycle(1'b1, 8'hF0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0);
        #2;
        chk("stall_hold", 32'(out_m), 32'd1);
        idle(12);
        chk("stall_stream", cap_m[7:0], 32'hF0);
`else
        // Parity frames: 0x07 -> 0,0,0,0,0,1,1,1,1 ; 0x03 -> parity bit 0
        clear_cap();
        cycle(1'b1, 8'h07, 1'b1);
        idle(12);
        chk("parity07", cap_m[8:0], 32'h00F);
        clear_cap();
        cycle(1'b1, 8'h03, 1'b1);
        idle(12);
        chk("parity03", cap_m[8:0], 32'h006);
`endif

        // Reset mid-word with a word held, then a clean word afterwards
        cycle(1'b1, 8'hAA, 1'b1);
        cycle(1'b1, 8'h55, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        #2;
        rst       = 1'b1;
        in_valid  = 1'b0;
        q.delete();
        cur_valid = 1'b0;
        #1;
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_midrst", 32'(rdy_m), 32'd1);
        clear_cap();
        cycle(1'b1, 8'h81, 1'b1);
        idle(14);
`ifndef SER_PARITY_EN
        chk("post_rst_msb", cap_m[15:0], 32'h0081);
        chk("post_rst_lsb", cap_l[15:0], 32'h0081);
`else
        chk("post_rst_msb", cap_m[17:0], 32'h00102);
`endif

        // Randomized traffic with random stalls
        for (int i = 0; i < 800; i++) begin
            cycle(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        idle(3 * int'(F));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
